// File: rtl/song_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// song_sequencer_pkg
// Shared constants for the song sequencer: the default beat length, the
// note-length codes, the note codes, the FSM state encodings and the layout
// of one song ROM word {note, len, led, last}.
// No ports; imported by song_rom and song_sequencer.
// ---------------------------------------------------------------------------
`ifndef CLK_FREQ
`define CLK_FREQ 50000000
`endif

package song_sequencer_pkg;

    // Clock cycles per beat at tempo x1 unless the instance overrides it.
    localparam int unsigned CLK_FREQ_DEFAULT = `CLK_FREQ;

    localparam int NOTE_ROM_W = 5;
    localparam int LEN_W      = 2;
    localparam int LED_W      = 8;

    // Length codes: the entry lasts beat >> len cycles.
    localparam logic [LEN_W-1:0] LEN_WHOLE   = 2'd0;
    localparam logic [LEN_W-1:0] LEN_HALF    = 2'd1;
    localparam logic [LEN_W-1:0] LEN_QUARTER = 2'd2;
    localparam logic [LEN_W-1:0] LEN_EIGHTH  = 2'd3;

    // Note codes understood by the buzzer driver; code 0 is silence.
    localparam logic [NOTE_ROM_W-1:0] NOTE_REST = 5'd0;
    localparam logic [NOTE_ROM_W-1:0] NOTE_C4   = 5'd1;
    localparam logic [NOTE_ROM_W-1:0] NOTE_CS4  = 5'd2;
    localparam logic [NOTE_ROM_W-1:0] NOTE_D4   = 5'd3;
    localparam logic [NOTE_ROM_W-1:0] NOTE_DS4  = 5'd4;
    localparam logic [NOTE_ROM_W-1:0] NOTE_E4   = 5'd5;
    localparam logic [NOTE_ROM_W-1:0] NOTE_F4   = 5'd6;
    localparam logic [NOTE_ROM_W-1:0] NOTE_FS4  = 5'd7;
    localparam logic [NOTE_ROM_W-1:0] NOTE_G4   = 5'd8;
    localparam logic [NOTE_ROM_W-1:0] NOTE_GS4  = 5'd9;
    localparam logic [NOTE_ROM_W-1:0] NOTE_A4   = 5'd10;
    localparam logic [NOTE_ROM_W-1:0] NOTE_AS4  = 5'd11;
    localparam logic [NOTE_ROM_W-1:0] NOTE_B4   = 5'd12;
    localparam logic [NOTE_ROM_W-1:0] NOTE_C5   = 5'd13;

    // Sequencer FSM state encodings.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // One song table entry as stored in the ROM.
    typedef struct packed {
        logic [NOTE_ROM_W-1:0] note;
        logic [LEN_W-1:0]      len;
        logic [LED_W-1:0]      led;
        logic                  last;
    } rom_word_t;

    // What any address outside a song's table reads back as.
    localparam rom_word_t ROM_UNUSED = '{note: NOTE_REST, len: LEN_WHOLE,
                                         led: 8'h00, last: 1'b1};

    function automatic rom_word_t mk_word(input logic [NOTE_ROM_W-1:0] note,
                                          input logic [LEN_W-1:0]      len,
                                          input logic [LED_W-1:0]      led,
                                          input logic                  last);
        rom_word_t w;
        w.note = note;
        w.len  = len;
        w.led  = led;
        w.last = last;
        return w;
    endfunction

    // Entry duration in cycles. A zero result (very fast tempo with a
    // short length) is stretched to one cycle so the sequencer never stalls.
    function automatic logic [31:0] entry_dur(input logic [31:0]      clkFreq,
                                              input logic [1:0]       tempo,
                                              input logic [LEN_W-1:0] len);
        logic [31:0] dur;
        dur = (clkFreq >> tempo) >> len;
        if (dur == 32'd0) begin
            dur = 32'd1;
        end
        return dur;
    endfunction

endpackage

// File: rtl/song_sequencer_song_rom.sv
// ---------------------------------------------------------------------------
// song_rom
// Holds every song table. One registered read port: the word for
// {i_song, i_addr} appears on o_word one clock after the address.
// Ports:
//   i_clk   - clock
//   i_song  - song number
//   i_addr  - entry index within the song
//   o_word  - registered ROM word {note, len, led, last}
// Song 0: three-entry tune with a rest in the middle.
// Song 1: four eighth notes.
// Song 2: fills the whole address space without a last flag.
// Song 3 and every unused address: rest with last set.
// ---------------------------------------------------------------------------
module song_rom
    import song_sequencer_pkg::*;
#(
    parameter int SONG_W = 2,
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic [SONG_W-1:0] i_song,
    input  logic [ADDR_W-1:0] i_addr,
    output rom_word_t         o_word
);

    rom_word_t r_word;

    function automatic rom_word_t f_lookup(input int song, input int addr);
        rom_word_t w;
        w = ROM_UNUSED;
        case (song)
            0: begin
                case (addr)
                    0:       w = mk_word(NOTE_G4,   LEN_HALF,    8'h01, 1'b0);
                    1:       w = mk_word(NOTE_REST, LEN_QUARTER, 8'h02, 1'b0);
                    2:       w = mk_word(NOTE_B4,   LEN_QUARTER, 8'h04, 1'b1);
                    default: w = ROM_UNUSED;
                endcase
            end
            1: begin
                case (addr)
                    0:       w = mk_word(NOTE_D4,  LEN_EIGHTH, 8'h10, 1'b0);
                    1:       w = mk_word(NOTE_E4,  LEN_EIGHTH, 8'h20, 1'b0);
                    2:       w = mk_word(NOTE_FS4, LEN_EIGHTH, 8'h40, 1'b0);
                    3:       w = mk_word(NOTE_GS4, LEN_EIGHTH, 8'h80, 1'b1);
                    default: w = ROM_UNUSED;
                endcase
            end
            2: begin
                // A running scale that never flags its own end; only the top
                // address stops it.
                w = mk_word(NOTE_ROM_W'((addr % 15) + 1), LEN_EIGHTH,
                            LED_W'(addr), 1'b0);
            end
            default: w = ROM_UNUSED;
        endcase
        return w;
    endfunction

    // Synchronous read: models a block ROM with one cycle of latency.
    always_ff @(posedge i_clk) begin
        r_word <= f_lookup(int'(i_song), int'(i_addr));
    end

    assign o_word = r_word;

endmodule

// File: rtl/song_sequencer.sv
// ---------------------------------------------------------------------------
// song_sequencer
// Walks through a song table in song_rom and plays each entry as a sounding
// window followed by a short silent tail, with pause, looping, tempo
// selection and restart on song change.
// Ports:
//   i_clk       - clock
//   i_rst       - synchronous active-high reset
//   i_en        - auto-play enable; low forces IDLE
//   i_pause     - freeze playback and silence the output while high
//   i_song_sel  - song number; a change while enabled restarts at entry 0
//   i_loop      - 1 restarts the song at its end, 0 stops in DONE
//   i_tempo_sel - beat = CLK_FREQ >> i_tempo_sel, picked up per entry
//   o_note      - note code to the buzzer (0 = silent)
//   o_led       - key indicator of the current entry
//   o_note_idx  - current entry index
//   o_playing   - in FETCH/PLAY/GAP and not paused
//   o_done      - one-cycle pulse when a non-looping song ends
// ---------------------------------------------------------------------------
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int unsigned CLK_FREQ = CLK_FREQ_DEFAULT,
    parameter int          NOTE_W   = 5,
    parameter int          SONG_W   = 2,
    parameter int          ADDR_W   = 6,
    parameter int unsigned GAP_DIV  = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_pause,
    input  logic [SONG_W-1:0] i_song_sel,
    input  logic              i_loop,
    input  logic [1:0]        i_tempo_sel,
    output logic [NOTE_W-1:0] o_note,
    output logic [7:0]        o_led,
    output logic [ADDR_W-1:0] o_note_idx,
    output logic              o_playing,
    output logic              o_done
);

    localparam int TIMER_W = $clog2(CLK_FREQ + 1);

    logic [2:0]         r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [ADDR_W-1:0]  r_idx;
    logic [NOTE_W-1:0]  r_note;
    logic [7:0]         r_led;
    logic               r_playing;
    logic               r_done;
    logic [SONG_W-1:0]  r_last_song;
    logic [NOTE_W-1:0]  r_entry_note;
    logic               r_entry_last;
    logic [TIMER_W-1:0] r_dur_m1;
    logic [TIMER_W-1:0] r_play_end;

    logic [2:0]         w_next_state;
    logic [TIMER_W-1:0] w_next_timer;
    logic [ADDR_W-1:0]  w_next_idx;
    logic [NOTE_W-1:0]  w_next_note;
    logic               w_next_playing;
    logic               w_next_done;
    logic               w_latch;
    logic               w_clear_led;
    logic               w_song_change;
    logic               w_is_last;
    logic               w_note_end;
    rom_word_t          w_rom_word;

    // Last timer value of the whole entry (dur - 1).
    function automatic logic [TIMER_W-1:0] f_dur_m1(input logic [1:0]       tempo,
                                                     input logic [LEN_W-1:0] len);
        logic [31:0] dur;
        dur = entry_dur(CLK_FREQ, tempo, len);
        return TIMER_W'(dur - 32'd1);
    endfunction

    // Last timer value of the sounding window. The silent tail is clamped
    // so at least one cycle always sounds, even with GAP_DIV of 1.
    function automatic logic [TIMER_W-1:0] f_play_end(input logic [1:0]       tempo,
                                                       input logic [LEN_W-1:0] len);
        logic [31:0] dur;
        logic [31:0] gap;
        dur = entry_dur(CLK_FREQ, tempo, len);
        gap = dur / 32'(GAP_DIV);
        if (gap >= dur) begin
            gap = dur - 32'd1;
        end
        return TIMER_W'(dur - gap - 32'd1);
    endfunction

    // The ROM is addressed with the index the FSM is about to hold, so the
    // word for a new entry is ready during its FETCH cycle.
    song_rom #(
        .SONG_W (SONG_W),
        .ADDR_W (ADDR_W)
    ) u_song_rom (
        .i_clk  (i_clk),
        .i_song (i_song_sel),
        .i_addr (w_next_idx),
        .o_word (w_rom_word)
    );

    assign w_song_change = i_en && (i_song_sel != r_last_song);
    // The top address ends the song even without its last flag, so the
    // index can never wrap back to 0 on its own.
    assign w_is_last     = r_entry_last || (r_idx == '1);
    // With no silent tail the entry ends straight out of PLAY.
    assign w_note_end    = (r_timer == r_dur_m1) &&
                           (r_state == ST_GAP ||
                            (r_state == ST_PLAY && r_play_end == r_dur_m1));

    // Next-state logic. Priority: enable low, then song change, then pause,
    // then ordinary sequencing.
    always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer;
        w_next_idx   = r_idx;
        w_next_done  = 1'b0;
        w_latch      = 1'b0;
        w_clear_led  = 1'b0;

        if (!i_en) begin
            w_next_state = ST_IDLE;
            w_next_timer = '0;
            w_next_idx   = '0;
            w_clear_led  = 1'b1;
        end else if (w_song_change) begin
            w_next_state = ST_FETCH;
            w_next_timer = '0;
            w_next_idx   = '0;
        end else if (i_pause) begin
            w_next_state = r_state;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_FETCH;
                    w_next_timer = '0;
                    w_next_idx   = '0;
                end
                ST_FETCH: begin
                    w_next_state = ST_PLAY;
                    w_next_timer = '0;
                    w_latch      = 1'b1;
                end
                ST_PLAY, ST_GAP: begin
                    if (w_note_end) begin
                        w_next_timer = '0;
                        if (!w_is_last) begin
                            w_next_state = ST_FETCH;
                            w_next_idx   = r_idx + ADDR_W'(1);
                        end else if (i_loop) begin
                            w_next_state = ST_FETCH;
                            w_next_idx   = '0;
                        end else begin
                            w_next_state = ST_DONE;
                            w_next_done  = 1'b1;
                        end
                    end else begin
                        w_next_timer = r_timer + TIMER_W'(1);
                        if (r_state == ST_PLAY && r_timer == r_play_end) begin
                            w_next_state = ST_GAP;
                        end
                    end
                end
                ST_DONE: begin
                    w_next_state = ST_DONE;
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_next_timer = '0;
                    w_next_idx   = '0;
                end
            endcase
        end
    end

    // Output values for the next cycle. The note comes straight from the
    // ROM on the FETCH exit because the entry register is loaded at the
    // same edge.
    always_comb begin
        w_next_note    = '0;
        w_next_playing = 1'b0;
        if (w_next_state == ST_PLAY && !i_pause) begin
            w_next_note = w_latch ? NOTE_W'(w_rom_word.note) : r_entry_note;
        end
        if ((w_next_state == ST_FETCH || w_next_state == ST_PLAY ||
             w_next_state == ST_GAP) && !i_pause) begin
            w_next_playing = 1'b1;
        end
    end

    // FSM, counters and output registers. The song select is sampled every
    // cycle so a change is seen exactly once.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_idx       <= '0;
            r_note      <= '0;
            r_playing   <= 1'b0;
            r_done      <= 1'b0;
            r_last_song <= i_song_sel;
        end else begin
            r_state     <= w_next_state;
            r_timer     <= w_next_timer;
            r_idx       <= w_next_idx;
            r_note      <= w_next_note;
            r_playing   <= w_next_playing;
            r_done      <= w_next_done;
            r_last_song <= i_song_sel;
        end
    end

    // Per-entry registers: loaded only on the FETCH exit, so the LED and
    // the entry's timing (including its tempo) stay fixed for the entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_entry_note <= '0;
            r_entry_last <= 1'b0;
            r_led        <= '0;
            r_dur_m1     <= '0;
            r_play_end   <= '0;
        end else if (w_latch) begin
            r_entry_note <= NOTE_W'(w_rom_word.note);
            r_entry_last <= w_rom_word.last;
            r_led        <= w_rom_word.led;
            r_dur_m1     <= f_dur_m1(i_tempo_sel, w_rom_word.len);
            r_play_end   <= f_play_end(i_tempo_sel, w_rom_word.len);
        end else if (w_clear_led) begin
            r_led <= '0;
        end
    end

    assign o_note     = r_note;
    assign o_led      = r_led;
    assign o_note_idx = r_idx;
    assign o_playing  = r_playing;
    assign o_done     = r_done;

endmodule
